// File: rtl/video_sync_pkg.sv
// Shared constants for the video_sync group: LSPC mode register bit positions
// and the raster timer width.
package video_sync_pkg;

    localparam int CNT_W             = 32;

    localparam int MODE_IRQ_EN       = 4;
    localparam int MODE_RELOAD_WRLOW = 5;
    localparam int MODE_RELOAD_VBL   = 6;
    localparam int MODE_RELOAD_ZERO  = 7;

endpackage

// File: rtl/lspc_timer_if.sv
// Register-write, raster-timing and interrupt signals between the 68k decode
// / video sync logic (master) and the raster timer (slave).
interface lspc_timer_if;
    import video_sync_pkg::*;

    logic             PCK_EN;
    logic [15:0]      DATA;
    logic             WR_MODE;
    logic             WR_TIMER_HIGH;
    logic             WR_TIMER_LOW;
    logic             WR_TIMER_STOP;
    logic             VBLANK_START;
    logic             PAL_STOP_LINE;
    logic             TIMER_IRQ;
    logic             TIMER_IRQ_EN;
    logic [CNT_W-1:0] COUNTER;

    modport master (
        output PCK_EN, DATA, WR_MODE, WR_TIMER_HIGH, WR_TIMER_LOW,
               WR_TIMER_STOP, VBLANK_START, PAL_STOP_LINE,
        input  TIMER_IRQ, TIMER_IRQ_EN, COUNTER
    );

    modport slave (
        input  PCK_EN, DATA, WR_MODE, WR_TIMER_HIGH, WR_TIMER_LOW,
               WR_TIMER_STOP, VBLANK_START, PAL_STOP_LINE,
        output TIMER_IRQ, TIMER_IRQ_EN, COUNTER
    );

endinterface

// File: rtl/lspc_timer.sv
// LSPC programmable raster timer: 32-bit down-counter on the pixel clock
// enable with reload sources, PAL line stop and a one-cycle expiry interrupt.
module lspc_timer
    import video_sync_pkg::*;
(
    input  logic         CLK,
    input  logic         nRESET,
    lspc_timer_if.slave  bus
);

    logic [CNT_W-1:0]                         reload_r;
    logic [CNT_W-1:0]                         counter_r;
    logic [MODE_RELOAD_ZERO:MODE_IRQ_EN]      mode_r;
    logic                                     stop_r;
    logic                                     irq_r;

    logic [CNT_W-1:0]                         reload_nxt_s;
    logic [CNT_W-1:0]                         counter_nxt_s;
    logic                                     halted_s;
    logic                                     expire_s;

    // Reload value as it stands after this cycle's half-word writes.
    always_comb begin
        reload_nxt_s = reload_r;
        if (bus.WR_TIMER_HIGH) begin
            reload_nxt_s[CNT_W-1:16] = bus.DATA;
        end else begin
            reload_nxt_s[CNT_W-1:16] = reload_r[CNT_W-1:16];
        end
        if (bus.WR_TIMER_LOW) begin
            reload_nxt_s[15:0] = bus.DATA;
        end else begin
            reload_nxt_s[15:0] = reload_r[15:0];
        end
    end

    // Counter next-state; reloads outrank expiry so a colliding expiry is lost.
    always_comb begin
        halted_s      = stop_r & bus.PAL_STOP_LINE;
        expire_s      = 1'b0;
        counter_nxt_s = counter_r;
        if (bus.WR_TIMER_LOW && mode_r[MODE_RELOAD_WRLOW]) begin
            counter_nxt_s = {reload_nxt_s[CNT_W-1:16], bus.DATA};
        end else if (bus.VBLANK_START && mode_r[MODE_RELOAD_VBL]) begin
            counter_nxt_s = reload_nxt_s;
        end else if (bus.PCK_EN && !halted_s) begin
            if (counter_r == {CNT_W{1'b0}}) begin
                expire_s = 1'b1;
                if (mode_r[MODE_RELOAD_ZERO]) begin
                    counter_nxt_s = reload_nxt_s;
                end else begin
                    counter_nxt_s = {CNT_W{1'b1}};
                end
            end else begin
                counter_nxt_s = counter_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            counter_nxt_s = counter_r;
        end
    end

    // Register file, counter and interrupt pulse.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            reload_r  <= {CNT_W{1'b0}};
            counter_r <= {CNT_W{1'b0}};
            mode_r    <= 4'b0000;
            stop_r    <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            reload_r  <= reload_nxt_s;
            counter_r <= counter_nxt_s;
            irq_r     <= expire_s & mode_r[MODE_IRQ_EN];
            if (bus.WR_MODE) begin
                mode_r <= bus.DATA[MODE_RELOAD_ZERO:MODE_IRQ_EN];
            end else begin
                mode_r <= mode_r;
            end
            if (bus.WR_TIMER_STOP) begin
                stop_r <= bus.DATA[0];
            end else begin
                stop_r <= stop_r;
            end
        end
    end

    assign bus.TIMER_IRQ    = irq_r;
    assign bus.TIMER_IRQ_EN = mode_r[MODE_IRQ_EN];
    assign bus.COUNTER      = counter_r;

endmodule

// File: doc/lspc_timer.md
Name: lspc_timer

Overview:
- Programmable 32-bit raster timer.
- Counts down on the pixel clock enable and produces the one-cycle TIMER_IRQ pulse that feeds the interrupt synchroniser / priority encoder directly downstream.
- Holds the timer reload value, the timer mode bits of the LSPC mode register, and the vblank-stop control.
- Sits inside the video_sync group, after the 68k register decode.

Parameters:
- CNT_W, 32, counter and reload width; fixed by hardware, do not change.

Ports:
- CLK  in  1  system clock
- nRESET  in  1  asynchronous active-low reset
- PCK_EN  in  1  pixel-clock enable (6 MHz tick), one CLK wide
- DATA  in  16  68k write data
- WR_MODE  in  1  write strobe, LSPC mode register (one CLK)
- WR_TIMER_HIGH  in  1  write strobe, reload[31:16]
- WR_TIMER_LOW  in  1  write strobe, reload[15:0]
- WR_TIMER_STOP  in  1  write strobe, stop control (DATA[0])
- VBLANK_START  in  1  one-CLK pulse, first line of vblank
- PAL_STOP_LINE  in  1  high during lines where PAL stop applies
- TIMER_IRQ  out  1  one-CLK pulse on counter expiry when enabled
- TIMER_IRQ_EN  out  1  mode bit 4, to irq stage
- COUNTER  out  32  current counter value (debug)

Behaviour:
- Reset values:
  - counter = 0, reload = 0, mode bits = 0, stop = 0.
  - TIMER_IRQ = 0, TIMER_IRQ_EN = 0.
- WR_MODE latches DATA[7:4] as {RELOAD_ZERO(7), RELOAD_VBL(6), RELOAD_WRLOW(5), IRQ_EN(4)}. Other bits are ignored here.
- WR_TIMER_HIGH latches reload[31:16]. WR_TIMER_LOW latches reload[15:0]. Both take effect in the same cycle.
- WR_TIMER_STOP latches stop = DATA[0].
- Counter update, evaluated every CLK. Priority is highest first; only one action applies:
  1. WR_TIMER_LOW with RELOAD_WRLOW = 1: counter <= {reload[31:16], DATA}. This uses the new low half and applies regardless of PCK_EN.
  2. VBLANK_START with RELOAD_VBL = 1: counter <= reload. Applies regardless of PCK_EN.
  3. PCK_EN, counter == 0, not halted: expiry.
     - RELOAD_ZERO = 1: counter <= reload.
     - RELOAD_ZERO = 0: counter <= 32'hFFFFFFFF (wrap).
  4. PCK_EN, counter != 0, not halted: counter <= counter - 1.
  5. Otherwise: hold.
- Halted = stop & PAL_STOP_LINE.
  - Halt freezes decrement and expiry only.
  - Reloads (cases 1 and 2) still apply while halted.
- TIMER_IRQ:
  - Registered; asserted exactly one CLK after the CLK in which case 3 fires, if IRQ_EN = 1 at that edge.
  - Width is exactly one CLK.
  - Never asserted by cases 1 or 2, even if the loaded value is 0.
  - If an expiry coincides with a reload (case 1 or 2 wins), no IRQ is produced.
- Reload = 0 with RELOAD_ZERO = 1: expiry on every PCK_EN tick, giving an IRQ every tick.
- TIMER_IRQ_EN mirrors IRQ_EN combinationally from the register. Clearing it does not cancel a pulse already registered.
- Reset asserted mid-count clears all state immediately. No IRQ is produced on reset release.

Decomposition:
- Shared package (video_sync_pkg) holds:
  - mode bit-position constants: MODE_IRQ_EN = 4, MODE_RELOAD_WRLOW = 5, MODE_RELOAD_VBL = 6, MODE_RELOAD_ZERO = 7;
  - CNT_W.
- No sub-module needed. The reload/mode registers and the counter fit in one module, roughly 150 lines.

Test Plan:
- Countdown: reload = 0x00000003, mode = 0xB0 (IRQ_EN, RELOAD_WRLOW, RELOAD_ZERO), write low 0x0003, apply PCK_EN ticks.
  - Counter steps 3,2,1,0.
  - The 4th tick reloads 3; TIMER_IRQ pulses one CLK later, one cycle wide.
  - Repeats every 4 ticks.
- Wrap: mode = 0x10, counter reaches 0.
  - Next tick gives counter = 0xFFFFFFFF with one TIMER_IRQ.
  - With IRQ_EN = 0, the same sequence gives no pulse.
- Vblank reload: mode = 0x40, reload = 0x100, counter = 0x20.
  - VBLANK_START gives counter = 0x100 the next cycle, no IRQ.
  - With mode = 0x00, VBLANK_START leaves the counter untouched.
- Collision: counter = 0 and PCK_EN in the same CLK as WR_TIMER_LOW with RELOAD_WRLOW = 1.
  - Counter loads the written value; TIMER_IRQ stays low.
- Stop: stop = 1, PAL_STOP_LINE = 1, counter = 5, 10 PCK_EN ticks.
  - Counter stays 5.
  - Deasserting PAL_STOP_LINE resumes the decrement on the next tick.
- Reset: assert nRESET low mid-count with a pulse pending.
  - All outputs are 0 asynchronously; no pulse after release.
